mod_counter: RTL and testbench
==============================

# mod_counter

Free-running modulo-N up-counter. It counts 0, 1, …, N-1 on successive clock edges, then wraps to 0. It serves as a basic timebase or sequencing source for surrounding logic, with a one-cycle terminal-count flag for cascading or event generation.

## Interface
Parameters:
- N, default 10: modulus; legal range 2 ≤ N ≤ 2^WIDTH.
- WIDTH, default 4: count register width in bits.

Ports:
- clk  input  1  rising-edge clock; the single clock domain.
- rst  input  1  asynchronous, active-low reset. Asserted while 0; deasserted synchronously by upstream reset logic.
- count  output  WIDTH  current count value, registered.
- tc  output  1  terminal-count flag. High exactly while count == N-1. Combinational decode of the count register, glitch-free from a single compare. Leaving it unconnected is legal.

## Operation
- Reset (rst == 0): count is forced to 0 immediately, without waiting for a clock edge. tc is 0, or 1 only in the degenerate case N == 1, which is illegal.
- Each rising clk edge with rst == 1:
  - if count == N-1, count becomes 0;
  - otherwise count becomes count + 1.
- Counting uses unsigned arithmetic in WIDTH bits. Wrap is decided by the compare against N-1, never by natural overflow, except when N == 2^WIDTH, where the two coincide.
- Out-of-range recovery: if count ≥ N (e.g. after SEU), the next edge loads 0. The compare is count ≥ N-1 → 0, so the counter returns to the legal sequence within one cycle.
- Reset mid-count: count drops to 0 asynchronously. Counting resumes from 0 on the first rising edge after rst returns to 1.
- There is no enable or load. The counter runs every cycle while out of reset.
- Elaboration check: N < 2 or N > 2^WIDTH must raise a fatal error via a generate-time $error or an initial assertion.

## Timing
- Latency: one cycle from a clock edge to the updated count.
- Period: the sequence repeats every N cycles.
- tc timing: tc is high for exactly one cycle in every N. The edge that ends the tc cycle loads 0.
- Release from reset: the first edge after release produces count = 1.
- Default sequence: 0,1,…,9,0,1,…
- All state is in a single WIDTH-bit register with an asynchronous clear.

## Structure
- Shared package (counter_pkg) holds:
  - default constants MOD_N_DEFAULT = 10 and MOD_WIDTH_DEFAULT = 4;
  - a clog2-based helper so integrators can derive WIDTH from N.
- No sub-module: one register plus a next-state mux and a comparator.
- An optional sub-module, mod_counter_cmp, may hold the ≥ N-1 compare if reused elsewhere. It is not required.

## Test plan
Testbenches use a 10 ns clock period and default parameters unless noted.

- Reset hold: drive rst = 0 for 10 ns with clk toggling → count = 0000 and tc = 0 throughout.
- Release and count: release rst at 10 ns → count steps 1, 2, … 9 on successive rising edges, then 0. tc is high only while count = 9. Check over 200 ns.
- Asynchronous reset mid-count: pull rst low between edges while count = 6 → count = 0 before the next edge, and it stays 0 while rst = 0. On release, the next edge gives 1.
- Period check: count tc pulses over 100 cycles → exactly 10 pulses, each 10 ns wide.
- Full-range modulus: set N = 16, WIDTH = 4 → sequence 0..15, 0 with no glitch at the wrap. tc is high at 15.
- Illegal value recovery: force count = 12 (N = 10) and release the force → the next edge loads 0 and normal counting follows.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared defaults and a width-derivation helper for the modulo-N counter family.
package counter_pkg;

  localparam int MOD_N_DEFAULT     = 10;
  localparam int MOD_WIDTH_DEFAULT = 4;

  // Smallest register width able to hold 0..n-1; at least one bit.
  function automatic int mod_width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_counter_cmp.sv
// Terminal-count decode: wrap when count >= N-1, flag exactly at N-1.
module mod_counter_cmp #(
  parameter int N     = 10,
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count_i,
  output logic             wrap_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

  // Using >= rather than == lets an out-of-range value fall back to 0 in one edge.
  assign wrap_o = (count_i >= LAST);
  assign tc_o   = (count_i == LAST);

endmodule

// File: rtl/mod_counter.sv
// Free-running modulo-N up-counter with a one-cycle terminal-count flag.
module mod_counter
  import counter_pkg::*;
#(
  parameter int N     = MOD_N_DEFAULT,
  parameter int WIDTH = MOD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  generate
    if (N < 2 || N > (1 << WIDTH)) begin : g_bad_params
      $error("mod_counter: N=%0d is outside 2..2**WIDTH (WIDTH=%0d)", N, WIDTH);
    end
  endgenerate

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap;

  mod_counter_cmp #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_cmp (
    .count_i (count_q),
    .wrap_o  (wrap),
    .tc_o    (tc)
  );

  assign count_d = wrap ? '0 : count_q + WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: default N=10 instance plus a full-range N=16 instance.
module tb_mod_counter;

  logic       clk;
  logic       rst;
  logic [3:0] count;
  logic       tc;
  logic [3:0] count16;
  logic       tc16;

  int checks;
  int errors;

  mod_counter dut (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .tc    (tc)
  );

  mod_counter #(.N(16), .WIDTH(4)) dut16 (
    .clk   (clk),
    .rst   (rst),
    .count (count16),
    .tc    (tc16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++;
      if (count !== 4'd0 || tc !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold t=%0t count=%0d tc=%b required count=0 tc=0", $time, count, tc);
      end else
        $display("reset_hold t=%0t count=%0d tc=%b ok", $time, count, tc);
    end
    #2;
    rst = 1'b1;
  endtask

  task automatic test_count();
    logic [3:0] exp_c;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      exp_c = 4'(i % 10);
      checks++;
      if (count !== exp_c || tc !== (exp_c == 4'd9)) begin
        errors++;
        $display("FAIL count_seq step=%0d count=%0d tc=%b required count=%0d tc=%b",
                 i, count, tc, exp_c, (exp_c == 4'd9));
      end else
        $display("count_seq step=%0d count=%0d tc=%b ok", i, count, tc);
    end
  endtask

  task automatic test_async_reset();
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (count == 4'd6) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL async_find count=%0d required 6 within 20 cycles", count);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL async_clear count=%0d required 0 before next edge", count);
    end else
      $display("async_clear t=%0t count=%0d ok", $time, count);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (count !== 4'd0 || tc !== 1'b0) begin
        errors++;
        $display("FAIL async_hold count=%0d tc=%b required count=0 tc=0", count, tc);
      end else
        $display("async_hold t=%0t count=%0d ok", $time, count);
    end
    @(negedge clk) rst = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (count !== 4'(i)) begin
        errors++;
        $display("FAIL async_resume count=%0d required %0d", count, i);
      end else
        $display("async_resume count=%0d ok", count);
    end
  endtask

  task automatic test_period();
    int pulses = 0;
    int high_cycles = 0;
    logic prev_tc;
    @(negedge clk);
    prev_tc = tc;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tc) high_cycles++;
      if (tc && !prev_tc) pulses++;
      prev_tc = tc;
    end
    checks++;
    if (pulses !== 10 || high_cycles !== 10) begin
      errors++;
      $display("FAIL period pulses=%0d high_cycles=%0d required pulses=10 high_cycles=10",
               pulses, high_cycles);
    end else
      $display("period pulses=%0d high_cycles=%0d ok", pulses, high_cycles);
  endtask

  task automatic test_full_range();
    logic [3:0] exp_c;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    checks++;
    if (count16 !== 4'd0 || tc16 !== 1'b0) begin
      errors++;
      $display("FAIL full_reset count=%0d tc=%b required count=0 tc=0", count16, tc16);
    end
    rst = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(posedge clk); #1;
      exp_c = 4'(i % 16);
      checks++;
      if (count16 !== exp_c || tc16 !== (exp_c == 4'd15)) begin
        errors++;
        $display("FAIL full_seq step=%0d count=%0d tc=%b required count=%0d tc=%b",
                 i, count16, tc16, exp_c, (exp_c == 4'd15));
      end else
        $display("full_seq step=%0d count=%0d tc=%b ok", i, count16, tc16);
    end
  endtask

  task automatic test_recovery();
    @(posedge clk);
    #2 force dut.count_q = 4'd12;
    #1 release dut.count_q;
    #1;
    checks++;
    if (count !== 4'd12 || tc !== 1'b0) begin
      errors++;
      $display("FAIL recover_forced count=%0d tc=%b required count=12 tc=0", count, tc);
    end else
      $display("recover_forced count=%0d tc=%b ok", count, tc);
    for (int i = 0; i <= 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (count !== 4'(i)) begin
        errors++;
        $display("FAIL recover_seq step=%0d count=%0d required %0d", i, count, i);
      end else
        $display("recover_seq step=%0d count=%0d ok", i, count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_count();
    test_async_reset();
    test_period();
    test_full_range();
    test_recovery();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
